// File: rtl/dpc_linebuf_ctrl.sv
// +--------------------------------------------------------------------------+
// | dpc_linebuf_ctrl: sequences LINES cascaded fifomem row-delay buffers and  |
// | presents a registered vertical pixel column to the DPC window.            |
// | Option macro: DPC_LB_BORDER_REPLICATE_EN (top-border replication).        |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module dpc_linebuf_ctrl #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 11,
  parameter int LINES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ASIZE:0]               cfg_width,
  input  logic                         i_sof,
  input  logic                         i_valid,
  input  logic [DSIZE-1:0]             i_data,
  output logic [ASIZE-1:0]             mem_addr,
  output logic [LINES-1:0]             mem_wclken,
  output logic [LINES*DSIZE-1:0]       mem_wdata,
  input  logic [LINES*DSIZE-1:0]       mem_rdata,
  output logic                         o_valid,
  output logic [(LINES+1)*DSIZE-1:0]   o_col,
  output logic [$clog2(LINES+1):0]     o_rows,
  output logic [ASIZE-1:0]             o_col_idx
);

  localparam int             c_rw        = $clog2(LINES+1) + 1;
  localparam logic [ASIZE:0] c_max_width = {1'b1, {ASIZE{1'b0}}};
  localparam logic [c_rw-1:0] c_lines    = c_rw'(LINES);

  logic [ASIZE:0]             r_width_q;
  logic [ASIZE-1:0]           r_col_cnt;
  logic [c_rw-1:0]            r_row_cnt;

  logic [ASIZE:0]             w_width_raw;
  logic [ASIZE:0]             w_width;
  logic [ASIZE-1:0]           w_col;
  logic [c_rw-1:0]            w_row;
  logic                       w_last;
  logic [DSIZE-1:0]           w_oldest;
  logic [(LINES+1)*DSIZE-1:0] w_col_nxt;

  // A start-of-frame pulse takes effect in its own cycle, so a colliding pixel is column 0 of row 0.
  assign w_width_raw = i_sof ? cfg_width : r_width_q;
  assign w_width     = (w_width_raw == '0 || w_width_raw > c_max_width) ? c_max_width : w_width_raw;
  assign w_col       = i_sof ? '0 : r_col_cnt;
  assign w_row       = i_sof ? '0 : r_row_cnt;
  assign w_last      = ({1'b0, w_col} == (w_width - 1'b1));

  assign mem_addr    = w_col;
  assign mem_wclken  = {LINES{i_valid}};

  generate
    for (genvar k = 0; k < LINES; k++) begin : g_wdata
      if (k == 0) begin : g_head
        assign mem_wdata[0 +: DSIZE] = i_data;
      end else begin : g_chain
        assign mem_wdata[k*DSIZE +: DSIZE] = mem_rdata[(k-1)*DSIZE +: DSIZE];
      end
    end
  endgenerate

  // Oldest filled row in the window; used to fill rows not yet written this frame.
  always_comb begin
    w_oldest = i_data;
    for (int k = 1; k <= LINES; k++) begin
      if (w_row == c_rw'(k)) begin
        w_oldest = mem_rdata[(k-1)*DSIZE +: DSIZE];
      end
    end
  end

  generate
    for (genvar j = 0; j <= LINES; j++) begin : g_slice
      if (j == 0) begin : g_new
        assign w_col_nxt[0 +: DSIZE] = i_data;
      end else begin : g_old
        logic [DSIZE-1:0] w_fill;
`ifdef DPC_LB_BORDER_REPLICATE_EN
        assign w_fill = w_oldest;
`else
        assign w_fill = '0;
`endif
        assign w_col_nxt[j*DSIZE +: DSIZE] = (c_rw'(j) <= w_row) ?
                                             mem_rdata[(j-1)*DSIZE +: DSIZE] : w_fill;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_width_q <= '0;
      r_col_cnt <= '0;
      r_row_cnt <= '0;
      o_valid   <= 1'b0;
      o_col     <= '0;
      o_rows    <= '0;
      o_col_idx <= '0;
    end else begin
      if (i_sof) begin
        r_width_q <= cfg_width;
        r_col_cnt <= '0;
        r_row_cnt <= '0;
      end
      if (i_valid) begin
        if (w_last) begin
          r_col_cnt <= '0;
          r_row_cnt <= (w_row == c_lines) ? w_row : w_row + 1'b1;
        end else begin
          r_col_cnt <= w_col + 1'b1;
          r_row_cnt <= w_row;
        end
        o_valid   <= 1'b1;
        o_col_idx <= w_col;
        o_col     <= w_col_nxt;
        o_rows    <= w_row;
      end else begin
        o_valid   <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dpc_linebuf_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_dpc_linebuf_ctrl: self-checking bench for dpc_linebuf_ctrl with a      |
// | behavioural fifomem array and a frame-history reference model.            |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_dpc_linebuf_ctrl;

  localparam int DSIZE = 8;
  localparam int ASIZE = 4;
  localparam int LINES = 4;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic [ASIZE:0]              cfg_width;
  logic                        i_sof;
  logic                        i_valid;
  logic [DSIZE-1:0]            i_data;
  logic [ASIZE-1:0]            mem_addr;
  logic [LINES-1:0]            mem_wclken;
  logic [LINES*DSIZE-1:0]      mem_wdata;
  logic [LINES*DSIZE-1:0]      mem_rdata;
  logic                        o_valid;
  logic [(LINES+1)*DSIZE-1:0]  o_col;
  logic [3:0]                  o_rows;
  logic [ASIZE-1:0]            o_col_idx;

  dpc_linebuf_ctrl #(.DSIZE(DSIZE), .ASIZE(ASIZE), .LINES(LINES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_width  (cfg_width),
    .i_sof      (i_sof),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .mem_addr   (mem_addr),
    .mem_wclken (mem_wclken),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .o_valid    (o_valid),
    .o_col      (o_col),
    .o_rows     (o_rows),
    .o_col_idx  (o_col_idx)
  );

  always #5 clk = ~clk;

  // Line memories: combinational read, write on clock edge.
  logic [DSIZE-1:0] mem [LINES][2**ASIZE];
  always @(posedge clk) begin
    for (int k = 0; k < LINES; k++)
      if (mem_wclken[k]) mem[k][mem_addr] <= mem_wdata[k*DSIZE +: DSIZE];
  end
  always_comb begin
    mem_rdata = '0;
    for (int k = 0; k < LINES; k++) mem_rdata[k*DSIZE +: DSIZE] = mem[k][mem_addr];
  end

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  // Reference model: frame position plus a history of pixels per (row, column).
  int          m_c, m_r, m_w;
  logic [7:0]  hist [8][16];
  logic        exp_valid;
  logic [39:0] exp_col;
  logic [3:0]  exp_rows;
  logic [3:0]  exp_idx;

`ifdef DPC_LB_BORDER_REPLICATE_EN
  localparam logic [39:0] BORDER_EXP = 40'h02_02_02_02_12;
`else
  localparam logic [39:0] BORDER_EXP = 40'h00_00_00_02_12;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit sof, input bit vld,
                      input logic [7:0] d, input logic [4:0] cw);
    logic [7:0] s [5];
    int rs;
    @(negedge clk);
    rst_n = !rst; i_sof = sof; i_valid = vld; i_data = d; cfg_width = cw;
    if (rst) begin
      m_c = 0; m_r = 0; m_w = 16;
      exp_valid = 0; exp_col = '0; exp_rows = '0; exp_idx = '0;
    end else begin
      if (sof) begin
        m_w = (cw == 0 || cw > 16) ? 16 : int'(cw);
        m_c = 0; m_r = 0;
      end
      #1;
      chk("mem_addr", 64'(mem_addr), 64'(m_c));
      chk("mem_wclken", 64'(mem_wclken), {60'd0, {4{vld}}});
      if (vld) begin
        hist[m_r % 8][m_c] = d;
        rs = (m_r > LINES) ? LINES : m_r;
        s[0] = d;
        for (int j = 1; j <= LINES; j++) begin
`ifdef DPC_LB_BORDER_REPLICATE_EN
          s[j] = (j <= rs) ? hist[(m_r - j) % 8][m_c] : s[rs];
`else
          s[j] = (j <= rs) ? hist[(m_r - j) % 8][m_c] : 8'h00;
`endif
        end
        exp_col  = {s[4], s[3], s[2], s[1], s[0]};
        exp_idx  = 4'(m_c);
        exp_rows = 4'(rs);
        m_c++;
        if (m_c == m_w) begin
          m_c = 0;
          m_r++;
        end
      end
      exp_valid = vld;
    end
    @(posedge clk);
    #1;
    chk("o_valid", 64'(o_valid), 64'(exp_valid));
    chk("o_col", 64'(o_col), 64'(exp_col));
    chk("o_rows", 64'(o_rows), 64'(exp_rows));
    chk("o_col_idx", 64'(o_col_idx), 64'(exp_idx));
  endtask

  initial begin
    int w, n;
    logic [39:0] held;
    rst_n = 1'b1; i_sof = 1'b0; i_valid = 1'b0; i_data = '0; cfg_width = '0;
    m_c = 0; m_r = 0; m_w = 16;
    exp_valid = 0; exp_col = '0; exp_rows = '0; exp_idx = '0;

    // T1: reset held with i_valid high
    step(1, 0, 1, 8'hAA, 5'd0);
    step(1, 0, 1, 8'h55, 5'd0);
    chk("t1_mem_addr", 64'(mem_addr), 64'd0);
    chk("t1_o_valid", 64'(o_valid), 64'd0);

    // T2 cascade + T5 border: width 8, five rows of row*16+col
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 8; c++) begin
        step(0, (r == 0 && c == 0), 1, 8'(r*16 + c), 5'd8);
        if (r == 1 && c == 2) chk("t5_border", 64'(o_col), 64'(BORDER_EXP));
        if (r == 4 && c == 3) begin
          chk("t2_col", 64'(o_col), 64'h03_13_23_33_43);
          chk("t2_rows", 64'(o_rows), 64'd4);
          chk("t2_idx", 64'(o_col_idx), 64'd3);
        end
      end

    // T3: width 5, six pixels
    for (int c = 0; c < 6; c++) step(0, (c == 0), 1, 8'($urandom), 5'd5);
    chk("t3_rows", 64'(o_rows), 64'd1);
    chk("t3_idx", 64'(o_col_idx), 64'd0);

    // T4: SOF collision mid-row, width re-sampled to 3
    for (int c = 0; c < 6; c++) step(0, (c == 0), 1, 8'($urandom), 5'd8);
    step(0, 1, 1, 8'h77, 5'd3);
    chk("t4_idx", 64'(o_col_idx), 64'd0);
    chk("t4_rows", 64'(o_rows), 64'd0);
    for (int c = 0; c < 4; c++) step(0, 0, 1, 8'($urandom), 5'd9);
    chk("t4_wrap_rows", 64'(o_rows), 64'd1);

    // Width boundaries: 0 and oversize both select 16
    step(0, 1, 1, 8'h01, 5'd0);
    for (int c = 1; c < 17; c++) step(0, 0, 1, 8'(c), 5'd0);
    chk("w0_rows", 64'(o_rows), 64'd1);
    step(0, 1, 1, 8'h02, 5'd20);
    for (int c = 1; c < 17; c++) step(0, 0, 1, 8'(c), 5'd1);
    chk("w20_rows", 64'(o_rows), 64'd1);

    // Randomized frames with gaps and abandoned lines
    for (int f = 0; f < 6; f++) begin
      w = $urandom_range(1, 31);
      n = $urandom_range(20, 110);
      step(0, 1, 1'($urandom), 8'($urandom), 5'(w));
      for (int i = 0; i < n; i++) step(0, 0, ($urandom_range(0, 3) != 0), 8'($urandom), 5'($urandom));
    end

    // T6: gaps then mid-frame reset
    step(0, 1, 1, 8'h10, 5'd6);
    held = o_col;
    step(0, 0, 0, 8'hEE, 5'd6);
    chk("t6_hold", 64'(o_col), 64'(held));
    step(0, 0, 1, 8'h11, 5'd6);
    step(1, 0, 0, 8'h00, 5'd6);
    chk("t6_rst_col", 64'(o_col), 64'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 5'd6);
    chk("t6_idle", 64'(o_valid), 64'd0);
    step(0, 1, 1, 8'h21, 5'd6);
    chk("t6_resume", 64'(o_valid), 64'd1);
    for (int c = 1; c < 12; c++) step(0, 0, 1, 8'($urandom), 5'd6);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
